// File: rtl/baud_pkg.sv
// baud_pkg: default widths, reset divisor and 50 MHz divisor table for baud_tick_gen
package baud_pkg;
   localparam int DEF_DIV_W = 16;
   localparam int DEF_FRAC_W = 4;
   localparam int DEF_OSR = 16;
   localparam int DEF_RST_DIV_INT = 324;
   localparam int DEF_RST_DIV_FRAC = 8;
   typedef enum logic [1:0] {BAUD_9600, BAUD_19200, BAUD_57600, BAUD_115200} baud_e;
   typedef struct packed {
      logic [15:0] div_int;
      logic [3:0] div_frac;
   } baud_div_t;
   function automatic baud_div_t baud_div(input baud_e b);
      return b == BAUD_9600 ? '{16'd324, 4'd8} :
             b == BAUD_19200 ? '{16'd161, 4'd12} :
             b == BAUD_57600 ? '{16'd53, 4'd4} : '{16'd26, 4'd2};
   endfunction
endpackage

// File: rtl/baud_tick_gen_mod_counter.sv
// mod_counter: wrap-at-limit counter (clk, rstn, en, clr, limit -> cnt, term)
module mod_counter #(
   parameter int W = 8
) (
   input logic clk,
   input logic rstn,
   input logic en,
   input logic clr,
   input logic [W-1:0] limit,
   output logic [W-1:0] cnt,
   output logic term
);
   assign term = en && cnt == limit;
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) cnt <= '0;
      else cnt <= (clr || term) ? '0 : en ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: fractional baud prescaler (clk, rstn, enable, restart, load, div_int, div_frac -> os_tick, bit_tick, mid_tick, cfg_pending)
module baud_tick_gen import baud_pkg::*; #(
   parameter int DIV_W = DEF_DIV_W,
   parameter int FRAC_W = DEF_FRAC_W,
   parameter int OSR = DEF_OSR,
   parameter int RST_DIV_INT = DEF_RST_DIV_INT,
   parameter int RST_DIV_FRAC = DEF_RST_DIV_FRAC
) (
   input logic clk,
   input logic rstn,
   input logic enable,
   input logic restart,
   input logic load,
   input logic [DIV_W-1:0] div_int,
   input logic [FRAC_W-1:0] div_frac,
   output logic os_tick,
   output logic bit_tick,
   output logic mid_tick,
   output logic cfg_pending
);
   localparam int OS_W = $clog2(OSR);
   logic [DIV_W-1:0] act_int, pend_int;
   logic [FRAC_W-1:0] act_frac, pend_frac, frac_acc;
   logic [FRAC_W:0] sum;
   logic [DIV_W:0] limit, cnt;
   logic [OS_W-1:0] os_cnt;
   logic pre_term, os_wrap, tick, direct;
   assign sum = {1'b0, frac_acc} + {1'b0, act_frac};
   // one extra bit keeps all-ones div_int plus carry from overflowing
   assign limit = {1'b0, act_int} + {{DIV_W{1'b0}}, sum[FRAC_W]};
   assign tick = pre_term && !restart;
   // loads that cannot split a running period are applied immediately
   assign direct = load && (tick || restart || !enable);
   mod_counter #(.W(DIV_W + 1)) u_pre (
      .clk(clk), .rstn(rstn), .en(enable), .clr(restart),
      .limit(limit), .cnt(cnt), .term(pre_term)
   );
   mod_counter #(.W(OS_W)) u_os (
      .clk(clk), .rstn(rstn), .en(tick), .clr(restart),
      .limit(OS_W'(OSR - 1)), .cnt(os_cnt), .term(os_wrap)
   );
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         os_tick <= 1'b0;
         bit_tick <= 1'b0;
         mid_tick <= 1'b0;
         cfg_pending <= 1'b0;
         frac_acc <= '0;
         act_int <= DIV_W'(RST_DIV_INT);
         act_frac <= FRAC_W'(RST_DIV_FRAC);
         pend_int <= '0;
         pend_frac <= '0;
      end else begin
         os_tick <= tick;
         bit_tick <= os_wrap;
         mid_tick <= tick && os_cnt == OS_W'(OSR / 2 - 1);
         frac_acc <= restart ? '0 : tick ? sum[FRAC_W-1:0] : frac_acc;
         if (direct) begin
            act_int <= div_int;
            act_frac <= div_frac;
            cfg_pending <= 1'b0;
         end else if (load) begin
            pend_int <= div_int;
            pend_frac <= div_frac;
            cfg_pending <= 1'b1;
         end else if (tick && cfg_pending) begin
            act_int <= pend_int;
            act_frac <= pend_frac;
            cfg_pending <= 1'b0;
         end
      end
endmodule
